// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - shared mode/state types and field widths for the immediate generator
package imm_pkg;

  localparam int IMM_INSTR_W     = 24;
  localparam int IMM_ROT_FIELD_W = 4;

  typedef enum logic [2:0] {
    IMM_ZX8    = 3'b000,
    IMM_ZX12   = 3'b001,
    IMM_BRANCH = 3'b010,
    IMM_ROTATE = 3'b011,
    IMM_OFFSET = 3'b100,
    IMM_RSV5   = 3'b101,
    IMM_RSV6   = 3'b110,
    IMM_RSV7   = 3'b111
  } imm_src_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROT  = 2'd1,
    OUT  = 2'd2
  } imm_state_e;

endpackage

// File: rtl/imm_gen_unit_if.sv
// rtl/imm_gen_unit_if.sv - request/result handshake bundle between decode and the immediate generator
interface imm_gen_unit_if #(
  parameter int DATA_W = 32
);
  import imm_pkg::*;

  logic                   flush_i;
  logic                   valid_i;
  logic                   ready_o;
  logic [IMM_INSTR_W-1:0] instr_i;
  logic [2:0]             imm_src_i;
  logic                   valid_o;
  logic                   ready_i;
  logic [DATA_W-1:0]      imm_o;
  logic                   carry_o;
  logic                   err_o;

  modport master (
    output flush_i, valid_i, instr_i, imm_src_i, ready_i,
    input  ready_o, valid_o, imm_o, carry_o, err_o
  );

  modport slave (
    input  flush_i, valid_i, instr_i, imm_src_i, ready_i,
    output ready_o, valid_o, imm_o, carry_o, err_o
  );

endinterface

// File: rtl/imm_rotator.sv
// rtl/imm_rotator.sv - combinational rotate-right of one word by a small variable amount, with carry-out
module imm_rotator
  import imm_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int AMT_W  = IMM_ROT_FIELD_W + 1
) (
  input  logic [DATA_W-1:0] i_data,
  input  logic [AMT_W-1:0]  i_amt,
  output logic [DATA_W-1:0] o_data,
  output logic              o_carry
);

  // A left shift by DATA_W yields zero, so amount 0 passes the word through unchanged.
  assign o_data  = (i_data >> i_amt) | (i_data << (DATA_W - int'(i_amt)));
  assign o_carry = (i_amt != '0) & o_data[DATA_W-1];

endmodule

// File: rtl/imm_gen_unit.sv
// rtl/imm_gen_unit.sv - registered immediate generator with valid/ready handshake and flush
// Define IMM_ROTATE_EN to compile in the multi-cycle rotated-imm8 mode (011).
module imm_gen_unit
  import imm_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ROT_PER_CYC = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  imm_gen_unit_if.slave bus
);

  if (!((DATA_W == 32 || DATA_W == 64) && ROT_PER_CYC >= 2 &&
        ROT_PER_CYC <= DATA_W && (ROT_PER_CYC % 2) == 0)) begin : g_bad_cfg
    $error("imm_gen_unit: unsupported DATA_W/ROT_PER_CYC combination");
  end

  imm_state_e        r_state;
  imm_state_e        w_state_nxt;
  imm_src_e          w_src;
  logic [DATA_W-1:0] r_imm;
  logic [DATA_W-1:0] w_imm_nr;
  logic [DATA_W-1:0] w_zx8;
  logic [DATA_W-1:0] w_zx12;
  logic              r_err;
  logic              w_err_nr;
  logic              w_ready;
  logic              w_accept;
  logic              w_rot_start;
  logic              w_rot_done;

  assign w_src  = imm_src_e'(bus.imm_src_i);
  assign w_zx8  = DATA_W'(bus.instr_i[7:0]);
  assign w_zx12 = DATA_W'(bus.instr_i[11:0]);

  always_comb begin
    w_imm_nr = '0;
    w_err_nr = 1'b0;
    case (w_src)
      IMM_ZX8:    w_imm_nr = w_zx8;
      IMM_ZX12:   w_imm_nr = w_zx12;
      IMM_BRANCH: w_imm_nr = {{(DATA_W-IMM_INSTR_W-2){bus.instr_i[IMM_INSTR_W-1]}},
                              bus.instr_i, 2'b00};
      IMM_OFFSET: w_imm_nr = bus.instr_i[IMM_INSTR_W-1] ? w_zx12 : ('0 - w_zx12);
`ifdef IMM_ROTATE_EN
      // Loaded unrotated; the ROT state walks it into place.
      IMM_ROTATE: w_imm_nr = w_zx8;
`endif
      default:    w_err_nr = 1'b1;
    endcase
  end

  assign w_ready     = !bus.flush_i & ((r_state == IDLE) | ((r_state == OUT) & bus.ready_i));
  assign w_accept    = bus.valid_i & w_ready;
  assign bus.ready_o = w_ready;

`ifdef IMM_ROTATE_EN
  localparam int REM_W = IMM_ROT_FIELD_W + 1;

  logic [REM_W-1:0]  r_rem;
  logic [REM_W-1:0]  w_rot_amt;
  logic [REM_W-1:0]  w_step;
  logic [DATA_W-1:0] w_rot_data;
  logic              w_rot_carry;
  logic              r_carry;

  assign w_rot_amt   = {bus.instr_i[11:8], 1'b0};
  assign w_rot_start = (w_src == IMM_ROTATE) & (w_rot_amt != '0);
  assign w_step      = (int'(r_rem) > ROT_PER_CYC) ? REM_W'(ROT_PER_CYC) : r_rem;
  assign w_rot_done  = (r_rem == w_step);

  imm_rotator #(
    .DATA_W (DATA_W),
    .AMT_W  (REM_W)
  ) u_rot (
    .i_data  (r_imm),
    .i_amt   (w_step),
    .o_data  (w_rot_data),
    .o_carry (w_rot_carry)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rem   <= '0;
      r_carry <= 1'b0;
    end else if (w_accept) begin
      r_rem   <= w_rot_amt;
      r_carry <= 1'b0;
    end else if ((r_state == ROT) && !bus.flush_i) begin
      r_rem   <= r_rem - w_step;
      r_carry <= w_rot_carry;
    end
  end

  assign bus.carry_o = r_carry;
`else
  assign w_rot_start = 1'b0;
  assign w_rot_done  = 1'b1;
  assign bus.carry_o = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    if (bus.flush_i) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_accept) w_state_nxt = w_rot_start ? ROT : OUT;
        ROT:     if (w_rot_done) w_state_nxt = OUT;
        OUT:     if (bus.ready_i) w_state_nxt = !w_accept ? IDLE : (w_rot_start ? ROT : OUT);
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_imm   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_imm <= w_imm_nr;
        r_err <= w_err_nr;
      end
`ifdef IMM_ROTATE_EN
      else if ((r_state == ROT) && !bus.flush_i) begin
        r_imm <= w_rot_data;
      end
`endif
    end
  end

  assign bus.valid_o = (r_state == OUT);
  assign bus.imm_o   = r_imm;
  assign bus.err_o   = r_err;

endmodule

// File: tb/tb_imm_gen_unit.sv
// tb/tb_imm_gen_unit.sv - directed self-checking bench for imm_gen_unit (DATA_W=32, ROT_PER_CYC=8)
// Rotate-mode expectations follow IMM_ROTATE_EN.
module tb_imm_gen_unit;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   seen;

  imm_gen_unit_if #(.DATA_W(32)) bus ();

  imm_gen_unit #(
    .DATA_W      (32),
    .ROT_PER_CYC (8)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Entered at a negedge with ready_i=1; the request is accepted at the next posedge.
  task automatic run_op(input string tag, input logic [2:0] src, input logic [23:0] ins,
                        input logic [31:0] exp_imm, input logic exp_err,
                        input logic exp_carry, input int exp_lat);
    int lat;
    bus.valid_i   = 1'b1;
    bus.imm_src_i = src;
    bus.instr_i   = ins;
    @(posedge clk);
    #1 bus.valid_i = 1'b0;
    lat = 1;
    @(negedge clk);
    while (bus.valid_o !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".lat"},   64'(lat),   64'(exp_lat));
    chk({tag, ".imm"},   bus.imm_o,   exp_imm);
    chk({tag, ".err"},   bus.err_o,   exp_err);
    chk({tag, ".carry"}, bus.carry_o, exp_carry);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    bus.flush_i   = 1'b0;
    bus.valid_i   = 1'b0;
    bus.ready_i   = 1'b1;
    bus.imm_src_i = 3'b000;
    bus.instr_i   = 24'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.valid", bus.valid_o, 1'b0);
    chk("rst.imm",   bus.imm_o,   32'h0);
    chk("rst.carry", bus.carry_o, 1'b0);
    chk("rst.err",   bus.err_o,   1'b0);
    rst = 1'b0;
    #1 chk("rst.ready", bus.ready_o, 1'b1);
    @(negedge clk);

    run_op("m0",     3'b000, 24'h0000AB, 32'h000000AB, 1'b0, 1'b0, 1);
    run_op("m1",     3'b001, 24'hFFFABC, 32'h00000ABC, 1'b0, 1'b0, 1);
    run_op("m2neg",  3'b010, 24'h800001, 32'hFE000004, 1'b0, 1'b0, 1);
    run_op("m2pos",  3'b010, 24'h000010, 32'h00000040, 1'b0, 1'b0, 1);
`ifdef IMM_ROTATE_EN
    run_op("m3r8",   3'b011, 24'h0004FF, 32'hFF000000, 1'b0, 1'b1, 2);
    run_op("m3r30",  3'b011, 24'h000F01, 32'h00000004, 1'b0, 1'b0, 5);
    run_op("m3r0",   3'b011, 24'h0000F2, 32'h000000F2, 1'b0, 1'b0, 1);
`else
    run_op("m3off",  3'b011, 24'h0004FF, 32'h00000000, 1'b1, 1'b0, 1);
`endif
    run_op("m4neg",  3'b100, 24'h000123, 32'hFFFFFEDD, 1'b0, 1'b0, 1);
    run_op("m4pos",  3'b100, 24'h800123, 32'h00000123, 1'b0, 1'b0, 1);
    run_op("m7",     3'b111, 24'hFFFFFF, 32'h00000000, 1'b1, 1'b0, 1);
    run_op("m5",     3'b101, 24'h0000AB, 32'h00000000, 1'b1, 1'b0, 1);

    // Back-pressure: hold the result while another request waits at the input.
    bus.valid_i   = 1'b1;
    bus.imm_src_i = 3'b000;
    bus.instr_i   = 24'h000055;
    @(posedge clk);
    #1;
    bus.ready_i = 1'b0;
    bus.instr_i = 24'h000001;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp.valid", bus.valid_o, 1'b1);
      chk("bp.imm",   bus.imm_o,   32'h00000055);
      chk("bp.ready", bus.ready_o, 1'b0);
    end
    bus.ready_i = 1'b1;
    bus.instr_i = 24'h000011;
    #1 chk("bp.ready_rel", bus.ready_o, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (i < 3) bus.instr_i = 24'(8'h11 * (i + 2));
      else       bus.valid_i = 1'b0;
      @(negedge clk);
      chk("b2b.valid", bus.valid_o, 1'b1);
      chk("b2b.imm",   bus.imm_o,   32'(8'h11 * (i + 1)));
    end
    @(negedge clk);
    chk("b2b.drain", bus.valid_o, 1'b0);

    // Flush drops a held result and beats a simultaneous request.
    bus.valid_i = 1'b1;
    bus.instr_i = 24'h000077;
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    @(negedge clk);
    chk("fo.valid_pre", bus.valid_o, 1'b1);
    chk("fo.imm_pre",   bus.imm_o,   32'h00000077);
    bus.flush_i = 1'b1;
    bus.valid_i = 1'b1;
    bus.instr_i = 24'h000099;
    bus.ready_i = 1'b1;
    #1 chk("fo.ready_flush", bus.ready_o, 1'b0);
    @(posedge clk);
    #1;
    bus.flush_i = 1'b0;
    bus.valid_i = 1'b0;
    @(negedge clk);
    chk("fo.valid", bus.valid_o, 1'b0);
    chk("fo.ready", bus.ready_o, 1'b1);
    chk("fo.imm",   bus.imm_o,   32'h00000077);

`ifdef IMM_ROTATE_EN
    bus.valid_i   = 1'b1;
    bus.imm_src_i = 3'b011;
    bus.instr_i   = 24'h000F01;
    @(posedge clk);
    #1 bus.valid_i = 1'b0;
    @(negedge clk);
    chk("fr.valid_rot", bus.valid_o, 1'b0);
    chk("fr.ready_rot", bus.ready_o, 1'b0);
    bus.flush_i = 1'b1;
    @(posedge clk);
    #1 bus.flush_i = 1'b0;
    @(negedge clk);
    chk("fr.valid", bus.valid_o, 1'b0);
    chk("fr.ready", bus.ready_o, 1'b1);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.valid_o === 1'b1) seen = 1;
    end
    chk("fr.no_result", 64'(seen), 64'd0);
`endif

    // Reset in the middle of an operation.
    bus.valid_i = 1'b1;
`ifdef IMM_ROTATE_EN
    bus.imm_src_i = 3'b011;
    bus.instr_i   = 24'h000F01;
`else
    bus.imm_src_i = 3'b100;
    bus.instr_i   = 24'h000001;
`endif
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    @(negedge clk);
`ifdef IMM_ROTATE_EN
    chk("rm.valid_pre", bus.valid_o, 1'b0);
`else
    chk("rm.valid_pre", bus.valid_o, 1'b1);
    chk("rm.imm_pre",   bus.imm_o,   32'hFFFFFFFF);
`endif
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rm.valid", bus.valid_o, 1'b0);
    chk("rm.imm",   bus.imm_o,   32'h0);
    chk("rm.carry", bus.carry_o, 1'b0);
    chk("rm.err",   bus.err_o,   1'b0);
    chk("rm.ready", bus.ready_o, 1'b1);

    bus.ready_i = 1'b1;
    run_op("post", 3'b001, 24'h000FFF, 32'h00000FFF, 1'b0, 1'b0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imm_gen_unit.md
# imm_gen_unit

Registered, parametrised immediate generator for the decode stage. It accepts a 24-bit instruction field and a mode code over a valid/ready handshake and returns a DATA_W-bit immediate. It replaces the combinational extender: zero-extend, branch sign-extend and shift, and signed offset modes complete in one cycle, and the rotated imm8 mode uses an iterative multi-cycle rotator. It sits between the instruction register and the operand mux and supports back-pressure and pipeline flush.

## Interface
- DATA_W, 32: immediate width; legal values 32 or 64.
- ROT_PER_CYC, 8: rotate-right bits per cycle; even, 2..DATA_W.
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset; synchronous and active-high.
- flush_i  in  1  discard the in-flight operation.
- valid_i  in  1  input request valid.
- ready_o  out  1  input accepted when valid_i & ready_o.
- instr_i  in  24  instruction bits [23:0].
- imm_src_i  in  3  mode code (see Operation).
- valid_o  out  1  result valid.
- ready_i  in  1  consumer ready; result retires on valid_o & ready_i.
- imm_o  out  DATA_W  immediate.
- carry_o  out  1  shifter carry-out (rotate mode only, else 0).
- err_o  out  1  undefined mode flag, qualified by valid_o.

## Operation
- Modes:
  - 000: zero-extend instr_i[7:0].
  - 001: zero-extend instr_i[11:0].
  - 010: sign-extend {instr_i[23:0],2'b00} from bit 25 to DATA_W.
  - 011: rotate-right of zero-extended instr_i[7:0] by 2*instr_i[11:8] within DATA_W. carry_o = imm_o[DATA_W-1] if the amount is ≠0, else 0.
  - 100: instr_i[11:0] zero-extended when instr_i[23]=1 (U bit); otherwise its two's-complement negation, modulo 2^DATA_W.
  - 101–111: imm_o=0, err_o=1, carry_o=0.
- FSM states:
  - IDLE → OUT: on accept, non-rotate mode or rotate amount 0.
  - IDLE → ROT: on accept, rotate amount ≠0.
  - ROT: each cycle rotate by min(remaining, ROT_PER_CYC) and subtract that from remaining. ROT → OUT when remaining reaches 0.
  - OUT: valid_o=1. Retire on ready_i.
  - OUT → IDLE: ready_i=1 and no new accept.
  - OUT → OUT or ROT: ready_i=1 with a simultaneous accept (back-to-back).
- ready_o = !flush_i & (IDLE | (OUT & ready_i)). ready_o is 0 in ROT.
- flush_i: next state is IDLE and valid_o=0 next cycle; any result held in OUT is discarded. Flush beats a simultaneous valid_i (no accept). imm_o retains its last value.
- rst_i overrides flush_i and everything else, including mid-ROT.
- Output stability: while valid_o & !ready_i, imm_o, carry_o and err_o are held stable.

## Timing
- Reset values: state IDLE, valid_o=0, imm_o=0, carry_o=0, err_o=0. ready_o=1 the cycle after reset when flush_i=0.
- Accept at edge k:
  - Non-rotate modes: valid_o high after edge k+1.
  - Rotate mode: valid_o high after edge k+1+ceil(2*rot/ROT_PER_CYC).
- Throughput: one result per cycle for non-rotate modes when ready_i is held high.
- All outputs except ready_o are registered. ready_o is combinational from state, ready_i and flush_i.

## Configuration
- IMM_ROTATE_EN defined: mode 011, the ROT state and the rotator are compiled in.
- IMM_ROTATE_EN undefined: mode 011 behaves like 101–111 (imm_o=0, err_o=1) with 1-cycle latency. ROT is unreachable, carry_o is tied to 0, and ROT_PER_CYC is ignored.

## Structure
- Package imm_pkg holds:
  - imm_src_e (3-bit mode enum);
  - imm_state_e (IDLE, ROT, OUT);
  - localparams IMM_INSTR_W=24 and IMM_ROT_FIELD_W=4.
- Sub-module imm_rotator: combinational rotate-right of a DATA_W word by a variable amount ≤ ROT_PER_CYC, with carry-out. It is instantiated once, under IMM_ROTATE_EN.

## Test plan
All cases use DATA_W=32, ROT_PER_CYC=8.
- Mode 000, instr 0x0000AB -> imm_o 0x000000AB, err_o 0, valid_o one cycle after accept.
- Mode 010, instr 0x800001 -> imm_o 0xFFFFFFFE... no: imm_o 0xFE000004. Instr 0x000010 -> 0x00000040.
- Mode 011:
  - instr 0x0004FF -> imm_o 0xFF000000, carry_o 1, valid_o at k+2.
  - instr 0x000F01 -> imm_o 0x00000004, carry_o 0, valid_o at k+5.
- Mode 100:
  - instr 0x000123 -> imm_o 0xFFFFFEDD.
  - instr 0x800123 -> imm_o 0x00000123.
  - Mode 111 -> imm_o 0, err_o 1.
- Back-pressure:
  - Hold ready_i=0 for 3 cycles -> imm_o stable, ready_o 0.
  - Then ready_i=1 with 4 back-to-back mode-000 requests -> 4 results on consecutive cycles.
- Flush and reset:
  - flush_i during ROT (instr 0x000F01) -> valid_o 0, ready_o 1 the next cycle, no result emitted.
  - rst_i asserted mid-ROT -> all outputs return to reset values after the next edge.
